// File: rtl/half_fetch_ctrl_pkg.sv
// Shared fetch definitions: FSM encoding, compressed-detect opcode, default reset PC.
package half_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOW   = 2'd1,
    ST_UPPER = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [1:0]  OPC_32       = 2'b11;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  // The icache returns each half-word byte-swapped relative to instruction order.
  function automatic logic [15:0] swap_half(input logic [15:0] d);
    return {d[7:0], d[15:8]};
  endfunction

endpackage

// File: rtl/half_fetch_ctrl_hw_decode.sv
// Combinational half-word decode: byte swap, then compressed-vs-32-bit classification.
module hw_decode
  import half_fetch_ctrl_pkg::*;
(
  input  logic [15:0] rdata_i,
  output logic        is_c_o
);

  logic [15:0] half;

  assign half = swap_half(rdata_i);
  // An all-zero half is treated as the low half of a 32-bit instruction.
  assign is_c_o = (half[1:0] != OPC_32) && (half != 16'h0000);

endmodule

// File: rtl/half_fetch_ctrl.sv
// Half-word fetch controller assembling 16/32-bit instructions; results are registered, 1 cycle after acceptance.
// Optional saturating perf counters are built only when HALF_FETCH_PERF_EN is defined.
module half_fetch_ctrl
  import half_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             jump,
  input  logic [31:0]      jump_target,
  input  logic             hazard_flush,
  output logic             icache_read,
  output logic [31:0]      icache_addr,
  input  logic             icache_ready,
  input  logic [15:0]      icache_rdata,
  output logic             hw_valid,
  output logic             instr_valid,
  output logic [31:0]      instr_pc,
  output logic             instr_is_c,
  output logic [CNT_W-1:0] perf_c_cnt,
  output logic [CNT_W-1:0] perf_w_cnt
);

  fetch_state_e state_q, state_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  pend_q, pend_d;
  logic [31:0]  tgt_q, tgt_d;
  logic [31:0]  pc_q, pc_d;
  logic         hwv_q, hwv_d;
  logic         iv_q, iv_d;
  logic         isc_q, isc_d;
  logic         is_c;
  logic [31:0]  jt;

  hw_decode u_hw_decode (
    .rdata_i (icache_rdata),
    .is_c_o  (is_c)
  );

  assign jt          = jump_target & ~32'h1;
  assign icache_read = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pend_d  = pend_q;
    tgt_d   = tgt_q;
    pc_d    = pc_q;
    isc_d   = isc_q;
    hwv_d   = hwv_q;
    iv_d    = iv_q;
    if (!stall) begin
      hwv_d = 1'b0;
      iv_d  = 1'b0;
      case (state_q)
        ST_IDLE: begin
          state_d = ST_LOW;
          if (jump) addr_d = jt;
        end
        ST_LOW, ST_UPPER: begin
          if (jump) begin
            // A request is always outstanding here; without data it must drain first.
            if (icache_ready) begin
              addr_d  = jt;
              state_d = ST_LOW;
            end else begin
              tgt_d   = jt;
              state_d = ST_DRAIN;
            end
          end else if (hazard_flush && (state_q == ST_UPPER)) begin
            state_d = ST_LOW;
          end else if (icache_ready) begin
            hwv_d  = 1'b1;
            addr_d = addr_q + 32'd2;
            if (state_q == ST_UPPER) begin
              iv_d    = 1'b1;
              isc_d   = 1'b0;
              pc_d    = pend_q;
              state_d = ST_LOW;
            end else if (is_c) begin
              iv_d  = 1'b1;
              isc_d = 1'b1;
              pc_d  = addr_q;
            end else begin
              pend_d  = addr_q;
              state_d = ST_UPPER;
            end
          end
        end
        ST_DRAIN: begin
          if (icache_ready) begin
            addr_d  = jump ? jt : tgt_q;
            state_d = ST_LOW;
          end else if (jump) begin
            tgt_d = jt;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= RESET_PC;
      pend_q  <= 32'h0;
      tgt_q   <= 32'h0;
      pc_q    <= 32'h0;
      hwv_q   <= 1'b0;
      iv_q    <= 1'b0;
      isc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pend_q  <= pend_d;
      tgt_q   <= tgt_d;
      pc_q    <= pc_d;
      hwv_q   <= hwv_d;
      iv_q    <= iv_d;
      isc_q   <= isc_d;
    end
  end

  assign icache_addr = addr_q;
  assign hw_valid    = hwv_q;
  assign instr_valid = iv_q;
  assign instr_pc    = pc_q;
  assign instr_is_c  = isc_q;

`ifdef HALF_FETCH_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] c_cnt_q, w_cnt_q;
  logic             inc_c, inc_w;

  // Gate with stall: iv_d merely holds the previous value while stalled.
  assign inc_c = !stall && iv_d && isc_d;
  assign inc_w = !stall && iv_d && !isc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      c_cnt_q <= '0;
      w_cnt_q <= '0;
    end else begin
      if (inc_c && (c_cnt_q != '1)) c_cnt_q <= c_cnt_q + CNT_ONE;
      if (inc_w && (w_cnt_q != '1)) w_cnt_q <= w_cnt_q + CNT_ONE;
    end
  end

  assign perf_c_cnt = c_cnt_q;
  assign perf_w_cnt = w_cnt_q;
`else
  assign perf_c_cnt = '0;
  assign perf_w_cnt = '0;
`endif

endmodule

// File: tb/tb_half_fetch_ctrl.sv
// Directed bench for half_fetch_ctrl with a scoreboard of expected delivered instructions.
module tb_half_fetch_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst, stall, jump, hazard_flush, icache_ready;
  logic [31:0]      jump_target;
  logic [15:0]      icache_rdata;
  logic             icache_read, hw_valid, instr_valid, instr_is_c;
  logic [31:0]      icache_addr, instr_pc;
  logic [CNT_W-1:0] perf_c_cnt, perf_w_cnt;

  typedef struct packed {
    logic [31:0] pc;
    logic        c;
  } exp_t;

  exp_t             sb[$];
  int               n_cmp = 0;
  int               n_err = 0;
  logic [CNT_W-1:0] mc = '0;
  logic [CNT_W-1:0] mw = '0;

  half_fetch_ctrl #(.RESET_PC(32'h0), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .jump         (jump),
    .jump_target  (jump_target),
    .hazard_flush (hazard_flush),
    .icache_read  (icache_read),
    .icache_addr  (icache_addr),
    .icache_ready (icache_ready),
    .icache_rdata (icache_rdata),
    .hw_valid     (hw_valid),
    .instr_valid  (instr_valid),
    .instr_pc     (instr_pc),
    .instr_is_c   (instr_is_c),
    .perf_c_cnt   (perf_c_cnt),
    .perf_w_cnt   (perf_w_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expect one delivered instruction; perf model follows the same saturating rule.
  task automatic push(input logic [31:0] pc, input logic c);
    exp_t e;
    e.pc = pc;
    e.c  = c;
    sb.push_back(e);
    if (c) begin
      if (mc != '1) mc = mc + 1'b1;
    end else begin
      if (mw != '1) mw = mw + 1'b1;
    end
  endtask

  task automatic check_perf(input string tag);
`ifdef HALF_FETCH_PERF_EN
    check({tag, "_c"}, {28'h0, perf_c_cnt}, {28'h0, mc});
    check({tag, "_w"}, {28'h0, perf_w_cnt}, {28'h0, mw});
`else
    check({tag, "_c"}, {28'h0, perf_c_cnt}, 32'h0);
    check({tag, "_w"}, {28'h0, perf_w_cnt}, 32'h0);
`endif
  endtask

  always @(negedge clk) begin
    if (instr_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_valid", {31'h0, instr_valid}, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_pc", instr_pc, e.pc);
        check("sb_is_c", {31'h0, instr_is_c}, {31'h0, e.c});
      end
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; jump = 1'b0; hazard_flush = 1'b0;
    icache_ready = 1'b0; jump_target = 32'h0; icache_rdata = 16'h0;

    cyc();
    check("rst_read", {31'h0, icache_read}, 32'h0);
    check("rst_addr", icache_addr, 32'h0);
    check("rst_hwv", {31'h0, hw_valid}, 32'h0);
    check("rst_iv", {31'h0, instr_valid}, 32'h0);
    check("rst_pc", instr_pc, 32'h0);
    check("rst_isc", {31'h0, instr_is_c}, 32'h0);
    check_perf("rst_perf");
    cyc();
    rst = 1'b0;
    #1;
    check("idle_read", {31'h0, icache_read}, 32'h0);
    cyc();
    check("low_read", {31'h0, icache_read}, 32'h1);
    check("low_addr", icache_addr, 32'h0);

    // Two compressed halves from address 0
    icache_ready = 1'b1; icache_rdata = 16'h4501; push(32'h0, 1'b1);
    cyc();
    check("c0_hwv", {31'h0, hw_valid}, 32'h1);
    check("c0_iv", {31'h0, instr_valid}, 32'h1);
    check("c0_addr", icache_addr, 32'h2);
    icache_rdata = 16'h8280; push(32'h2, 1'b1);
    cyc();
    check("c1_addr", icache_addr, 32'h4);
    icache_ready = 1'b0;
    cyc();
    check("idle_hwv", {31'h0, hw_valid}, 32'h0);

    // Jump coinciding with returned data: redirect now, data dropped
    jump = 1'b1; jump_target = 32'h100; icache_ready = 1'b1; icache_rdata = 16'h4501;
    cyc();
    check("jr_addr", icache_addr, 32'h100);
    check("jr_hwv", {31'h0, hw_valid}, 32'h0);
    check("jr_iv", {31'h0, instr_valid}, 32'h0);
    jump = 1'b0; icache_rdata = 16'h9300;
    cyc();
    check("w_lo_hwv", {31'h0, hw_valid}, 32'h1);
    check("w_lo_iv", {31'h0, instr_valid}, 32'h0);
    check("w_lo_addr", icache_addr, 32'h102);
    icache_rdata = 16'h0000; push(32'h100, 1'b0);
    cyc();
    check("w_hi_iv", {31'h0, instr_valid}, 32'h1);
    check("w_hi_isc", {31'h0, instr_is_c}, 32'h0);
    check("w_hi_pc", instr_pc, 32'h100);
    check("w_hi_addr", icache_addr, 32'h104);
    icache_ready = 1'b0;
    cyc();

    // Stall with data available freezes everything
    stall = 1'b1; icache_ready = 1'b1; icache_rdata = 16'h4501;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall_hwv", {31'h0, hw_valid}, 32'h0);
      check("stall_addr", icache_addr, 32'h104);
      check_perf("stall_perf");
    end
    stall = 1'b0; icache_ready = 1'b0;
    cyc();

    // Jump while in UPPER discards the pending low half
    icache_ready = 1'b1; icache_rdata = 16'h9300;
    cyc();
    check("up_addr", icache_addr, 32'h106);
    jump = 1'b1; jump_target = 32'h2003; icache_rdata = 16'h0000;
    cyc();
    check("ju_addr", icache_addr, 32'h2002);
    check("ju_iv", {31'h0, instr_valid}, 32'h0);
    jump = 1'b0; icache_rdata = 16'h4501; push(32'h2002, 1'b1);
    cyc();
    check("ju_next_addr", icache_addr, 32'h2004);

    // Jump with the request unanswered: drain before redirect
    icache_ready = 1'b0; jump = 1'b1; jump_target = 32'h3000;
    cyc();
    check("dr_addr0", icache_addr, 32'h2004);
    check("dr_read", {31'h0, icache_read}, 32'h1);
    jump = 1'b0;
    cyc();
    check("dr_addr1", icache_addr, 32'h2004);
    icache_ready = 1'b1; icache_rdata = 16'h4501;
    cyc();
    check("dr_hwv", {31'h0, hw_valid}, 32'h0);
    check("dr_iv", {31'h0, instr_valid}, 32'h0);
    check("dr_addr2", icache_addr, 32'h3000);

    // Hazard flush drops the partial instruction but keeps the address
    icache_rdata = 16'h9300;
    cyc();
    icache_ready = 1'b0; hazard_flush = 1'b1;
    cyc();
    check("fl_addr", icache_addr, 32'h3002);
    hazard_flush = 1'b0; icache_ready = 1'b1; icache_rdata = 16'h8280; push(32'h3002, 1'b1);
    cyc();
    check("fl_next_addr", icache_addr, 32'h3004);

    // Address wrap at the top of the space
    jump = 1'b1; jump_target = 32'hFFFF_FFFF;
    cyc();
    check("wr_addr0", icache_addr, 32'hFFFF_FFFE);
    jump = 1'b0; icache_rdata = 16'h4501; push(32'hFFFF_FFFE, 1'b1);
    cyc();
    check("wr_addr1", icache_addr, 32'h0);
    check_perf("mid_perf");

    // Reset mid-instruction overrides stall and jump
    icache_rdata = 16'h9300;
    cyc();
    rst = 1'b1; stall = 1'b1; jump = 1'b1; jump_target = 32'h500; icache_rdata = 16'h0000;
    mc = '0; mw = '0;
    cyc();
    check("mr_read", {31'h0, icache_read}, 32'h0);
    check("mr_addr", icache_addr, 32'h0);
    check("mr_iv", {31'h0, instr_valid}, 32'h0);
    check("mr_hwv", {31'h0, hw_valid}, 32'h0);
    check("mr_pc", instr_pc, 32'h0);
    check_perf("mr_perf");
    rst = 1'b0; stall = 1'b0; jump = 1'b0; icache_ready = 1'b0;
    cyc();
    check("mr_low_addr", icache_addr, 32'h0);

    // 17 compressed instructions to saturate the 4-bit counter
    icache_ready = 1'b1; icache_rdata = 16'h4501;
    for (int i = 0; i < 17; i++) begin
      push(32'(2 * i), 1'b1);
      cyc();
      check("sat_hwv", {31'h0, hw_valid}, 32'h1);
    end
    icache_ready = 1'b0;
    cyc();
    check_perf("sat_perf");
`ifdef HALF_FETCH_PERF_EN
    check("sat_c_full", {28'h0, perf_c_cnt}, 32'hF);
`endif
    cyc();
    check("sb_drained", sb.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
